// File: rtl/seg_scan_ctrl_if.sv
// Display-controller bus: value/dp load side plus the scanned digit/segment outputs.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                blank_lz;
    logic                load;
    logic                busy;
    logic                frame_start;
    logic [DIGITS-1:0]   seg_sel;
    logic [6:0]          segment;
    logic                dp;

    modport master (
        output value, dp_in, blank_lz, load,
        input  busy, frame_start, seg_sel, segment, dp
    );

    modport slave (
        input  value, dp_in, blank_lz, load,
        output busy, frame_start, seg_sel, segment, dp
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous loading, leading-zero
// blanking and per-slot dead time. Define SEG_SCAN_DP_EN to build decimal-point support.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned BLANK_CYC   = 1000,
    parameter int unsigned SEL_ACT_LOW = 1,
    parameter int unsigned SEG_ACT_LOW = 1
) (
    input  logic          clk_100MHz,
    input  logic          rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned VAL_W  = 4 * DIGITS;

    localparam logic [DIGITS-1:0] SEL_INV = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (SEG_ACT_LOW != 0);

    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic              slot_end_c;
    logic              frame_wrap_c;
    logic              in_blank_c;

    logic [VAL_W-1:0]  pend_val;
    logic [VAL_W-1:0]  shad_val;
    logic              pend_v;

    logic [DIGITS-1:0] lz_c;
    logic [3:0]        nib_c;
    logic              blank_digit_c;
    logic [DIGITS-1:0] sel_c;
    logic [6:0]        seg_c;
    logic              dp_c;

    logic [DIGITS-1:0] sel_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic              fs_q;

    // Active-high gfedcba hex font
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign slot_end_c   = (pcnt == PCNT_W'(SCAN_DIV - 1));
    assign frame_wrap_c = slot_end_c && (idx == IDX_W'(DIGITS - 1));

    generate
        if (BLANK_CYC > 0) begin : g_blank
            assign in_blank_c = (pcnt < PCNT_W'(BLANK_CYC));
        end else begin : g_no_blank
            assign in_blank_c = 1'b0;
        end
    endgenerate

    // Slot prescaler and digit index
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end_c) begin
            pcnt <= '0;
            idx  <= frame_wrap_c ? '0 : idx + IDX_W'(1);
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // Pending/shadow pair: shadow only changes on a frame wrap so a frame never tears
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            pend_val <= '0;
            shad_val <= '0;
            pend_v   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            if (frame_wrap_c && pend_v) shad_val <= pend_val;
            if (bus.load)               pend_val <= bus.value;
            pend_v <= bus.load | (pend_v & ~frame_wrap_c);
            fs_q   <= frame_wrap_c;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0] pend_dp;
    logic [DIGITS-1:0] shad_dp;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            pend_dp <= '0;
            shad_dp <= '0;
        end else begin
            if (frame_wrap_c && pend_v) shad_dp <= pend_dp;
            if (bus.load)               pend_dp <= bus.dp_in;
        end
    end
`else
    logic unused_dp_in;
    assign unused_dp_in = ^bus.dp_in;
`endif

    // lz_c[i] marks digits whose nibble and every more-significant nibble are zero
    always_comb begin
        logic run;
        lz_c = '0;
        run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run     = run && (shad_val[4*i +: 4] == 4'h0);
            lz_c[i] = run;
        end
    end

    always_comb begin
        nib_c         = 4'h0;
        sel_c         = '0;
        blank_digit_c = 1'b0;
        dp_c          = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_c         = shad_val[4*i +: 4];
                sel_c[i]      = 1'b1;
                blank_digit_c = bus.blank_lz && lz_c[i];
`ifdef SEG_SCAN_DP_EN
                dp_c          = shad_dp[i];
`endif
            end
        end
        seg_c = hex_to_seg(nib_c);
        if (blank_digit_c) begin
            seg_c = 7'h00;
            dp_c  = 1'b0;
        end
        // Dead time at slot start keeps the previous digit's segments from ghosting
        if (in_blank_c) begin
            sel_c = '0;
            seg_c = 7'h00;
            dp_c  = 1'b0;
        end
    end

    // Output registers; polarity is applied only here
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            sel_q <= SEL_INV;
            seg_q <= SEG_INV;
            dp_q  <= DP_INV;
        end else begin
            sel_q <= sel_c ^ SEL_INV;
            seg_q <= seg_c ^ SEG_INV;
            dp_q  <= dp_c ^ DP_INV;
        end
    end

    assign bus.seg_sel     = sel_q;
    assign bus.segment     = seg_q;
    assign bus.dp          = dp_q;
    assign bus.busy        = pend_v;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, active-low outputs.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
`ifdef SEG_SCAN_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    logic clk_100MHz = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [3:0] cap_dark_sel [4];
    logic       cap_dark_dp  [4];
    logic [3:0] cap_sel      [4];
    logic [6:0] cap_seg      [4];
    logic       cap_dp       [4];

    always #5 clk_100MHz = ~clk_100MHz;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .SEL_ACT_LOW(1),
        .SEG_ACT_LOW(1)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst       (rst),
        .bus       (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
        bus.value = v;
        bus.dp_in = dpv;
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
    endtask

    // Wait (bounded) for a frame_start cycle
    task automatic sync_frame(input string name);
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        tests++;
        if (bus.frame_start !== 1'b1) begin
            fails++;
            $display("FAIL %s: frame_start not seen within 100 cycles", name);
        end
    endtask

    // From a frame_start cycle, sample each slot once dark and once lit; ends on the next frame_start cycle
    task automatic capture_frame;
        for (int d = 0; d < 4; d++) begin
            tick(2);
            cap_dark_sel[d] = bus.seg_sel;
            cap_dark_dp[d]  = bus.dp;
            tick(2);
            cap_sel[d] = bus.seg_sel;
            cap_seg[d] = bus.segment;
            cap_dp[d]  = bus.dp;
            tick(4);
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        tick(3);
        tests++; if (bus.seg_sel !== 4'hF) begin fails++; $display("FAIL rst_sel: got %h expected %h", bus.seg_sel, 4'hF); end
        tests++; if (bus.segment !== 7'h7F) begin fails++; $display("FAIL rst_seg: got %h expected %h", bus.segment, 7'h7F); end
        tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL rst_dp: got %b expected 1", bus.dp); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs: got %b expected 0", bus.frame_start); end
        rst = 1'b0;
        tick(2);
        tests++; if (bus.seg_sel !== 4'hF) begin fails++; $display("FAIL rst_dark2: got %h expected %h", bus.seg_sel, 4'hF); end
        tick(1);
        tests++; if (bus.seg_sel !== 4'b1110) begin fails++; $display("FAIL rst_first_sel: got %b expected 1110", bus.seg_sel); end
        tests++; if (bus.segment !== 7'h40) begin fails++; $display("FAIL rst_first_seg: got %h expected %h", bus.segment, 7'h40); end
        tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL rst_first_dp: got %b expected 1", bus.dp); end
        tick(6);
        tests++; if (bus.seg_sel !== 4'hF) begin fails++; $display("FAIL rst_slot1_dark: got %h expected %h", bus.seg_sel, 4'hF); end
        tick(2);
        tests++; if (bus.seg_sel !== 4'b1101) begin fails++; $display("FAIL rst_slot1_sel: got %b expected 1101", bus.seg_sel); end
        tick(16);
        tests++; if (bus.seg_sel !== 4'b0111) begin fails++; $display("FAIL rst_slot3_sel: got %b expected 0111", bus.seg_sel); end
        tick(4);
        tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs_early: got %b expected 0", bus.frame_start); end
        tick(1);
        tests++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL rst_fs_wrap: got %b expected 1", bus.frame_start); end
        tick(1);
        tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs_pulse: got %b expected 0", bus.frame_start); end
    endtask

    task automatic test_load_sync;
        logic [6:0] exp_seg [4];
        bit early;
        int n;
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        sync_frame("ls_sync0");
        tick(5);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ls_busy_idle: got %b expected 0", bus.busy); end
        do_load(16'h12AF, 4'b0000);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ls_busy_rise: got %b expected 1", bus.busy); end
        early = 1'b0;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 100) begin
            if (bus.busy !== 1'b1) early = 1'b1;
            tick(1);
            n++;
        end
        tests++; if (early) begin fails++; $display("FAIL ls_busy_hold: got busy=0 before frame_start expected 1"); end
        sync_frame("ls_sync1");
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ls_busy_fall: got %b expected 0", bus.busy); end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            logic [3:0] esel;
            esel = ~(4'b0001 << d);
            tests++; if (cap_sel[d] !== esel) begin fails++; $display("FAIL ls_sel%0d: got %b expected %b", d, cap_sel[d], esel); end
            tests++; if (cap_seg[d] !== exp_seg[d]) begin fails++; $display("FAIL ls_seg%0d: got %h expected %h", d, cap_seg[d], exp_seg[d]); end
            tests++; if (cap_dark_sel[d] !== 4'hF) begin fails++; $display("FAIL ls_dark%0d: got %h expected F", d, cap_dark_sel[d]); end
        end
    endtask

    task automatic test_lz;
        logic [6:0] exp_on  [4];
        logic [6:0] exp_off [4];
        exp_on  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        exp_off = '{7'h40, 7'h12, 7'h40, 7'h40};
        bus.blank_lz = 1'b1;
        do_load(16'h0050, 4'b1111);
        sync_frame("lz_sync");
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            logic [3:0] esel;
            logic       edp;
            esel = ~(4'b0001 << d);
            edp  = (d >= 2) ? 1'b1 : ~DP_ON;
            tests++; if (cap_sel[d] !== esel) begin fails++; $display("FAIL lz_sel%0d: got %b expected %b", d, cap_sel[d], esel); end
            tests++; if (cap_seg[d] !== exp_on[d]) begin fails++; $display("FAIL lz_seg%0d: got %h expected %h", d, cap_seg[d], exp_on[d]); end
            tests++; if (cap_dp[d] !== edp) begin fails++; $display("FAIL lz_dp%0d: got %b expected %b", d, cap_dp[d], edp); end
        end
        bus.blank_lz = 1'b0;
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            logic edp;
            edp = ~DP_ON;
            tests++; if (cap_seg[d] !== exp_off[d]) begin fails++; $display("FAIL nolz_seg%0d: got %h expected %h", d, cap_seg[d], exp_off[d]); end
            tests++; if (cap_dp[d] !== edp) begin fails++; $display("FAIL nolz_dp%0d: got %b expected %b", d, cap_dp[d], edp); end
        end
    endtask

    task automatic test_overwrite;
        tick(3);
        do_load(16'h1111, 4'b0000);
        tick(5);
        do_load(16'h2222, 4'b0000);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ow_busy: got %b expected 1", bus.busy); end
        sync_frame("ow_sync");
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ow_busy_fall: got %b expected 0", bus.busy); end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++; if (cap_seg[d] !== 7'h24) begin fails++; $display("FAIL ow_seg%0d: got %h expected %h", d, cap_seg[d], 7'h24); end
        end
    endtask

    task automatic test_back_to_back;
        tick(5);
        do_load(16'h4444, 4'b0000);
        tick(25);
        tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL bb_pre_fs: got %b expected 0", bus.frame_start); end
        do_load(16'h3333, 4'b0000);
        tests++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL bb_fs: got %b expected 1", bus.frame_start); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL bb_busy_hold: got %b expected 1", bus.busy); end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++; if (cap_seg[d] !== 7'h19) begin fails++; $display("FAIL bb_old_seg%0d: got %h expected %h", d, cap_seg[d], 7'h19); end
        end
        tests++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL bb_fs2: got %b expected 1", bus.frame_start); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bb_busy_fall: got %b expected 0", bus.busy); end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++; if (cap_seg[d] !== 7'h30) begin fails++; $display("FAIL bb_new_seg%0d: got %h expected %h", d, cap_seg[d], 7'h30); end
        end
    endtask

    task automatic test_reset_mid;
        tick(20);
        do_load(16'h5555, 4'b1111);
        tests++; if (bus.seg_sel !== 4'b1011) begin fails++; $display("FAIL rm_pre_sel: got %b expected 1011", bus.seg_sel); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rm_pre_busy: got %b expected 1", bus.busy); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.seg_sel !== 4'hF) begin fails++; $display("FAIL rm_sel: got %h expected F", bus.seg_sel); end
        tests++; if (bus.segment !== 7'h7F) begin fails++; $display("FAIL rm_seg: got %h expected %h", bus.segment, 7'h7F); end
        tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL rm_dp: got %b expected 1", bus.dp); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b expected 0", bus.busy); end
        tick(2);
        rst = 1'b0;
        tick(3);
        tests++; if (bus.seg_sel !== 4'b1110) begin fails++; $display("FAIL rm_restart_sel: got %b expected 1110", bus.seg_sel); end
        tests++; if (bus.segment !== 7'h40) begin fails++; $display("FAIL rm_restart_seg: got %h expected %h", bus.segment, 7'h40); end
        sync_frame("rm_sync");
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rm_busy_after: got %b expected 0", bus.busy); end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++; if (cap_seg[d] !== 7'h40) begin fails++; $display("FAIL rm_shadow_seg%0d: got %h expected %h", d, cap_seg[d], 7'h40); end
            tests++; if (cap_dp[d] !== 1'b1) begin fails++; $display("FAIL rm_shadow_dp%0d: got %b expected 1", d, cap_dp[d]); end
        end
    endtask

    task automatic test_dp;
        logic [6:0] exp_seg [4];
        logic [3:0] dpv;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        dpv = 4'b0101;
        do_load(16'h1234, dpv);
        sync_frame("dp_sync");
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            logic edp;
            edp = (DP_ON && dpv[d]) ? 1'b0 : 1'b1;
            tests++; if (cap_seg[d] !== exp_seg[d]) begin fails++; $display("FAIL dp_seg%0d: got %h expected %h", d, cap_seg[d], exp_seg[d]); end
            tests++; if (cap_dp[d] !== edp) begin fails++; $display("FAIL dp_lit%0d: got %b expected %b", d, cap_dp[d], edp); end
            tests++; if (cap_dark_dp[d] !== 1'b1) begin fails++; $display("FAIL dp_dark%0d: got %b expected 1", d, cap_dark_dp[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_sync();
        test_lz();
        test_overwrite();
        test_back_to_back();
        test_reset_mid();
        test_dp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
